// File: rtl/stack_op_sequencer_if.sv
// Instruction handshake between decode (master) and the stack sequencer (slave).
// An instruction transfers on a rising edge where instr_valid and instr_ready are both 1.
// The producer holds opcode/imm stable until that edge.
interface stack_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] imm;

  modport master (output instr_valid, output opcode, output imm, input instr_ready);
  modport slave  (input instr_valid, input opcode, input imm, output instr_ready);
endinterface

// File: rtl/stack_op_sequencer.sv
// Stack-machine instruction sequencer: turns opcodes into register_stack commands,
// tracks depth, rejects under/overflow and expands DUP2 into two pushes.
module stack_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  stack_op_sequencer_if.slave  instr,
  input  logic                 clr_err,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2:0]           stackOP,
  output logic [WIDTH-1:0]     w,
  output logic [DW-1:0]        depth,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_DUP2_B = 1'b1} state_t;

  localparam logic [DW-1:0] LP_DEPTH    = DW'(DEPTH);
  localparam logic [DW-1:0] LP_DEPTH_M1 = DW'(DEPTH - 1);
  localparam logic [DW-1:0] LP_DEPTH_M2 = DW'(DEPTH - 2);

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_PUSH = 3'd1;
  localparam logic [2:0] C_BIN  = 3'd2;
  localparam logic [2:0] C_POP  = 3'd3;
  localparam logic [2:0] C_POP2 = 3'd4;
  localparam logic [2:0] C_SWAP = 3'd5;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_depth, w_depth_nxt;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic             w_accept;
  logic [DW-1:0]    w_min, w_max;
  logic [DW-1:0]    w_up, w_dn;
  logic [2:0]       w_cmd;
  logic [WIDTH-1:0] w_data;
  logic             w_illegal;
  logic             w_is_dup2;
  logic [1:0]       w_fault;

  // Per-opcode requirements: legal depth window, depth change and the command to issue.
  always_comb begin
    w_min     = '0;
    w_max     = LP_DEPTH;
    w_up      = '0;
    w_dn      = '0;
    w_cmd     = C_NOP;
    w_data    = '0;
    w_illegal = 1'b0;
    w_is_dup2 = 1'b0;
    case (instr.opcode)
      4'd0:  ;
      4'd1:  begin w_max = LP_DEPTH_M1; w_up = DW'(1); w_cmd = C_PUSH; w_data = instr.imm; end
      4'd2:  begin w_min = DW'(2); w_dn = DW'(1); w_cmd = C_BIN; w_data = b + a; end
      4'd3:  begin w_min = DW'(2); w_dn = DW'(1); w_cmd = C_BIN; w_data = b - a; end
      4'd4:  begin w_min = DW'(2); w_dn = DW'(1); w_cmd = C_BIN; w_data = b & a; end
      4'd5:  begin w_min = DW'(2); w_dn = DW'(1); w_cmd = C_BIN; w_data = b | a; end
      4'd6:  begin w_min = DW'(1); w_dn = DW'(1); w_cmd = C_POP; end
      4'd7:  begin w_min = DW'(2); w_dn = DW'(2); w_cmd = C_POP2; end
      4'd8:  begin w_min = DW'(2); w_cmd = C_SWAP; end
      4'd9:  begin w_min = DW'(1); w_max = LP_DEPTH_M1; w_up = DW'(1); w_cmd = C_PUSH; w_data = a; end
      4'd10: begin w_min = DW'(2); w_max = LP_DEPTH_M1; w_up = DW'(1); w_cmd = C_PUSH; w_data = b; end
      4'd11: begin
        w_min = DW'(2); w_max = LP_DEPTH_M2; w_up = DW'(2);
        w_cmd = C_PUSH; w_data = b; w_is_dup2 = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal)             w_fault = 2'd3;
    else if (r_depth < w_min)  w_fault = 2'd1;
    else if (r_depth > w_max)  w_fault = 2'd2;
    else                       w_fault = 2'd0;
  end

  assign w_accept = (r_state == S_IDLE) && instr.instr_valid && !RST;

  // Outputs are gated by RST directly so an asynchronous reset silences the stack at once.
  always_comb begin
    stackOP     = C_NOP;
    w           = '0;
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    if (!RST) begin
      if (r_state == S_DUP2_B) begin
        // The first push made the original a the new b.
        stackOP     = C_PUSH;
        w           = b;
        w_state_nxt = S_IDLE;
      end else if (w_accept && (w_fault == 2'd0)) begin
        stackOP     = w_cmd;
        w           = w_data;
        w_depth_nxt = r_depth + w_up - w_dn;
        if (w_is_dup2) w_state_nxt = S_DUP2_B;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      if (w_accept && (w_fault != 2'd0)) begin
        r_err <= 1'b1;
        if (!r_err || clr_err) r_err_code <= w_fault;
      end else if (clr_err) begin
        r_err      <= 1'b0;
        r_err_code <= 2'd0;
      end
    end
  end

  assign instr.instr_ready = (r_state == S_IDLE) && !RST;
  assign busy              = (r_state == S_DUP2_B);
  assign depth             = r_depth;
  assign err               = r_err;
  assign err_code          = r_err_code;
  assign dbg_state         = r_state;

endmodule
